// File: rtl/port_egress_rx.sv
// Egress receiver for one switch output: per-port legality check, DEPTH-entry FIFO,
// registered valid/ready head stage, and saturating receive/drop/error statistics.
module port_egress_rx #(
    parameter int PORT_ID      = 0,
    parameter int PACKET_WIDTH = 16,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sw_valid,
    input  logic [PACKET_WIDTH-1:0]   sw_data,
    input  logic [1:0]                sw_type,
    output logic                      sw_ready,
    output logic                      m_valid,
    output logic [PACKET_WIDTH-1:0]   m_data,
    output logic [1:0]                m_type,
    input  logic                      m_ready,
    output logic [CNT_W-1:0]          rx_cnt,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic [CNT_W-1:0]          err_cnt,
    output logic                      err_sticky,
    input  logic                      err_clr,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int EW = PACKET_WIDTH + 2;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    state_t          state, state_nx;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [OW-1:0]   used;
    logic            full, empty, pop;
    logic [3:0]      src, tgt;
    logic [2:0]      src_ones, tgt_ones;
    logic            type_ok, legal;
    logic            accept, drop_evt, err_evt;

    assign src      = sw_data[3:0];
    assign tgt      = sw_data[7:4];
    assign src_ones = ones4(src);
    assign tgt_ones = ones4(tgt);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        type_ok = 1'b0;
        case (sw_type)
            2'd0:    type_ok = (tgt_ones == 3'd1);
            2'd1:    type_ok = (tgt_ones >= 3'd2);
            2'd2:    type_ok = (tgt == 4'hF);
            default: type_ok = 1'b0;
        endcase
        legal = tgt[PORT_ID] && (src_ones == 3'd1) && type_ok;
    end

    assign full     = (used == OW'(DEPTH));
    assign empty    = (used == '0);
    assign sw_ready = !full;

    // Full is judged on pre-pop occupancy; a same-cycle pop still frees the slot.
    assign err_evt  = sw_valid && !legal;
    assign accept   = sw_valid && legal && (!full || pop);
    assign drop_evt = sw_valid && legal && full && !pop;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            EMPTY: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = EMPTY;
                    end
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    assign m_valid = (state == HOLD);

    // NOTE: the storage array is not reset; pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {sw_type, sw_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    // Head register: loads from storage whenever the FSM pops, otherwise holds steady.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data <= '0;
            m_type <= '0;
        end else if (pop) begin
            {m_type, m_data} <= mem[rd_ptr];
        end
    end

    assign fifo_count = used + OW'(state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt   <= '0;
            drop_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (accept && (rx_cnt != '1)) begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (drop_evt && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (err_evt && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (err_evt) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_port_egress_rx.sv
// Randomised and directed bench for port_egress_rx against a queue-based reference model;
// a second instance with 4-bit counters exposes saturation cheaply.
module tb_port_egress_rx;

    localparam int PORT_ID = 2;
    localparam int DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst, sw_valid, m_ready, err_clr;
    logic [15:0] sw_data;
    logic [1:0]  sw_type;

    logic        sw_ready, m_valid, err_sticky;
    logic [15:0] m_data, rx_cnt, drop_cnt, err_cnt;
    logic [1:0]  m_type;
    logic [3:0]  fifo_count;

    logic        sw_ready_s, m_valid_s, err_sticky_s;
    logic [15:0] m_data_s;
    logic [1:0]  m_type_s;
    logic [3:0]  rx_cnt_s, drop_cnt_s, err_cnt_s, fifo_count_s;

    port_egress_rx #(.PORT_ID(PORT_ID), .PACKET_WIDTH(16), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sw_valid(sw_valid), .sw_data(sw_data), .sw_type(sw_type),
        .sw_ready(sw_ready), .m_valid(m_valid), .m_data(m_data), .m_type(m_type),
        .m_ready(m_ready), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt),
        .err_sticky(err_sticky), .err_clr(err_clr), .fifo_count(fifo_count)
    );

    port_egress_rx #(.PORT_ID(PORT_ID), .PACKET_WIDTH(16), .DEPTH(DEPTH), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .sw_valid(sw_valid), .sw_data(sw_data), .sw_type(sw_type),
        .sw_ready(sw_ready_s), .m_valid(m_valid_s), .m_data(m_data_s), .m_type(m_type_s),
        .m_ready(m_ready), .rx_cnt(rx_cnt_s), .drop_cnt(drop_cnt_s), .err_cnt(err_cnt_s),
        .err_sticky(err_sticky_s), .err_clr(err_clr), .fifo_count(fifo_count_s)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: storage queue, head slot, event counts.
    logic [17:0] mq[$];
    logic [17:0] head;
    bit          head_v;
    bit          sticky;
    int          c_rx, c_drop, c_err;
    logic [17:0] exp_q[$];
    logic [17:0] obs_q[$];

    function automatic bit legal(input logic [15:0] d, input logic [1:0] t);
        logic [3:0] s, g;
        s = d[3:0];
        g = d[7:4];
        if (!g[PORT_ID]) return 1'b0;
        if ($countones(s) != 1) return 1'b0;
        case (t)
            2'd0:    return $countones(g) == 1;
            2'd1:    return $countones(g) >= 2;
            2'd2:    return g == 4'hF;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sat16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    function automatic logic [3:0] sat4(input int c);
        return (c > 15) ? 4'hF : 4'(c);
    endfunction

    function automatic logic [84:0] dut_state();
        return {m_valid, (m_valid ? m_type : 2'b00), (m_valid ? m_data : 16'h0000),
                sw_ready, err_sticky, fifo_count, rx_cnt, drop_cnt, err_cnt,
                rx_cnt_s, drop_cnt_s, err_cnt_s};
    endfunction

    function automatic logic [84:0] model_state();
        logic [17:0] h;
        logic        rdy;
        h   = head_v ? head : 18'h0;
        rdy = (mq.size() < DEPTH);
        return {head_v, h[17:16], h[15:0], rdy, sticky,
                4'(mq.size() + (head_v ? 1 : 0)),
                sat16(c_rx), sat16(c_drop), sat16(c_err),
                sat4(c_rx), sat4(c_drop), sat4(c_err)};
    endfunction

    task automatic model_update(input logic r, input logic v, input logic [15:0] d,
                                input logic [1:0] t, input logic rdy, input logic clr);
        bit hs, pop, acc, new_err;
        if (r) begin
            mq.delete();
            head_v = 0; sticky = 0;
            c_rx = 0; c_drop = 0; c_err = 0;
            return;
        end
        hs      = head_v && rdy;
        pop     = (mq.size() > 0) && (!head_v || rdy);
        acc     = 0;
        new_err = 0;
        if (v) begin
            if (!legal(d, t)) begin
                c_err++;
                new_err = 1;
            end else if (mq.size() == DEPTH && !pop) begin
                c_drop++;
            end else begin
                c_rx++;
                acc = 1;
            end
        end
        if (new_err) sticky = 1;
        else if (clr) sticky = 0;
        if (hs) exp_q.push_back(head);
        if (pop) begin
            head   = mq.pop_front();
            head_v = 1;
        end else if (hs) begin
            head_v = 0;
        end
        if (acc) mq.push_back({t, d});
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] d,
                        input logic [1:0] t, input logic rdy, input logic clr);
        rst = r; sw_valid = v; sw_data = d; sw_type = t; m_ready = rdy; err_clr = clr;
        if (!r && m_valid && m_ready) obs_q.push_back({m_type, m_data});
        @(posedge clk);
        model_update(r, v, d, t, rdy, clr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0);
        total++;
        if (dut_state() !== model_state()) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", dut_state(), model_state());
        end
        total++;
        if ({m_valid, m_data, m_type, fifo_count, sw_ready} !== {1'b0, 16'h0, 2'd0, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs got v=%b d=%h t=%0d cnt=%0d rdy=%b want 0/0000/0/0/1",
                     m_valid, m_data, m_type, fifo_count, sw_ready);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0041 | 16'(i << 8), 2'd0, 1'b0, 1'b0);
        total++;
        if (fifo_count !== 4'd5) begin
            bad++;
            $display("FAIL reset_prefill got=%0d want=5", fifo_count);
        end
        step(1'b1, 1'b1, 16'h0041, 2'd0, 1'b1, 1'b0);
        total++;
        if ({m_valid, rx_cnt, fifo_count, sw_ready} !== {1'b0, 16'd0, 4'd0, 1'b1} ||
            dut_state() !== model_state()) begin
            bad++;
            $display("FAIL reset_midflight got=%h want=%h", dut_state(), model_state());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_basic();
        do_reset();
        step(1'b0, 1'b1, 16'h5A41, 2'd0, 1'b1, 1'b0);
        total++;
        if (m_valid !== 1'b0 || fifo_count !== 4'd1) begin
            bad++;
            $display("FAIL basic_write got v=%b cnt=%0d want v=0 cnt=1", m_valid, fifo_count);
        end
        step(1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        total++;
        if ({m_valid, m_data, m_type, rx_cnt, err_cnt} !== {1'b1, 16'h5A41, 2'd0, 16'd1, 16'd0}) begin
            bad++;
            $display("FAIL basic_out got v=%b d=%h t=%0d rx=%0d err=%0d want 1/5a41/0/1/0",
                     m_valid, m_data, m_type, rx_cnt, err_cnt);
        end
        step(1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        total++;
        if (m_valid !== 1'b0 || obs_q.size() != 1 || dut_state() !== model_state()) begin
            bad++;
            $display("FAIL basic_drain got v=%b n=%0d want v=0 n=1", m_valid, obs_q.size());
        end
    endtask

    task automatic test_errors();
        do_reset();
        step(1'b0, 1'b1, 16'h0011, 2'd0, 1'b1, 1'b0);
        total++;
        if ({err_cnt, err_sticky, fifo_count} !== {16'd1, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL err_misroute got err=%0d sticky=%b cnt=%0d want 1/1/0", err_cnt, err_sticky, fifo_count);
        end
        step(1'b0, 1'b1, 16'h0071, 2'd2, 1'b1, 1'b0);
        total++;
        if (err_cnt !== 16'd2) begin
            bad++;
            $display("FAIL err_bcast got=%0d want=2", err_cnt);
        end
        step(1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b1);
        total++;
        if ({err_sticky, err_cnt} !== {1'b0, 16'd2}) begin
            bad++;
            $display("FAIL err_clear got sticky=%b err=%0d want 0/2", err_sticky, err_cnt);
        end
        step(1'b0, 1'b1, 16'h0011, 2'd0, 1'b1, 1'b1);
        total++;
        if ({err_sticky, err_cnt} !== {1'b1, 16'd3}) begin
            bad++;
            $display("FAIL err_set_wins got sticky=%b err=%0d want 1/3", err_sticky, err_cnt);
        end
        step(1'b0, 1'b1, 16'h0041, 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0041, 2'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0043, 2'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h00C1, 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h00F1, 2'd2, 1'b1, 1'b0);
        total++;
        if ({rx_cnt, err_cnt} !== {16'd2, 16'd6} || dut_state() !== model_state()) begin
            bad++;
            $display("FAIL err_mix got rx=%0d err=%0d want 2/6", rx_cnt, err_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 16'h0041 | 16'(i << 8), 2'd0, 1'b0, 1'b0);
        total++;
        if ({rx_cnt, drop_cnt, fifo_count, sw_ready, m_data} !== {16'd9, 16'd3, 4'd9, 1'b0, 16'h0041}) begin
            bad++;
            $display("FAIL overflow_counts got rx=%0d drop=%0d cnt=%0d rdy=%b head=%h want 9/3/9/0/0041",
                     rx_cnt, drop_cnt, fifo_count, sw_ready, m_data);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        total++;
        if (obs_q.size() != 9) begin
            bad++;
            $display("FAIL overflow_drain_count got=%0d want=9", obs_q.size());
        end
        for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== {2'd0, 16'h0041 | 16'(i << 8)}) begin
                bad++;
                $display("FAIL overflow_order idx=%0d got=%h want=%h", i, obs_q[i], {2'd0, 16'h0041 | 16'(i << 8)});
            end
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h00C1 | 16'(i << 8), 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'h7741, 2'd0, 1'b1, 1'b0);
        total++;
        if ({drop_cnt, rx_cnt, fifo_count} !== {16'd0, 16'd10, 4'd9}) begin
            bad++;
            $display("FAIL full_pop got drop=%0d rx=%0d cnt=%0d want 0/10/9", drop_cnt, rx_cnt, fifo_count);
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        total++;
        if (obs_q.size() != 10 || obs_q[9] !== {2'd0, 16'h7741} || obs_q != exp_q) begin
            bad++;
            $display("FAIL full_pop_order got n=%0d want n=10 last=07741", obs_q.size());
        end
    endtask

    function automatic logic [17:0] rand_pkt();
        logic [1:0]  t;
        logic [3:0]  s, g;
        logic [7:0]  p;
        int          r;
        r = $urandom_range(0, 15);
        t = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 14) ? 2'd2 : 2'd3;
        s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        case (t)
            2'd0:    g = 4'b0100;
            2'd1:    g = 4'($urandom) | 4'b0100;
            default: g = 4'hF;
        endcase
        if ($urandom_range(0, 4) == 0) g = 4'($urandom);
        p = 8'($urandom);
        return {t, p, g, s};
    endfunction

    task automatic test_random();
        logic [17:0] pk;
        int          diffs;
        do_reset();
        diffs = 0;
        for (int i = 0; i < 400; i++) begin
            pk = rand_pkt();
            step(1'b0, $urandom_range(0, 4) != 0, pk[15:0], pk[17:16],
                 $urandom_range(0, 9) < 4, $urandom_range(0, 7) == 0);
            total++;
            if (dut_state() !== model_state()) begin
                bad++;
                diffs++;
                if (diffs < 6) $display("FAIL random_state cycle=%0d got=%h want=%h", i, dut_state(), model_state());
            end
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 16'h0, 2'd0, 1'b1, 1'b0);
        total++;
        if (obs_q != exp_q || fifo_count !== 4'd0) begin
            bad++;
            $display("FAIL random_order got n=%0d want n=%0d cnt=%0d", obs_q.size(), exp_q.size(), fifo_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 65540; i++) step(1'b0, 1'b1, 16'h0041 | 16'(i << 8), 2'd0, 1'b1, 1'b0);
        total++;
        if ({rx_cnt, rx_cnt_s} !== {16'hFFFF, 4'hF} || dut_state() !== model_state()) begin
            bad++;
            $display("FAIL rx_saturate got rx=%h rx_s=%h want ffff/f", rx_cnt, rx_cnt_s);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'h0011, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 16'h0041, 2'd0, 1'b0, 1'b0);
        total++;
        if ({rx_cnt, err_cnt_s, drop_cnt_s, err_cnt} !== {16'hFFFF, 4'hF, 4'hF, 16'd20} ||
            dut_state() !== model_state()) begin
            bad++;
            $display("FAIL small_saturate got rx=%h err_s=%h drop_s=%h err=%0d want ffff/f/f/20",
                     rx_cnt, err_cnt_s, drop_cnt_s, err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; sw_valid = 1'b0; sw_data = '0; sw_type = '0; m_ready = 1'b0; err_clr = 1'b0;
        head = '0; head_v = 0; sticky = 0; c_rx = 0; c_drop = 0; c_err = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_errors();
        test_overflow();
        test_full_pop();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/port_egress_rx.md
Name: port_egress_rx

Overview:
- Egress-side receiver attached to one output of switch_4port; the receiving counterpart of the per-port ingress path (port_if driver -> fifo -> switch_port).
- Accepts packets the switch delivers to this port and checks that each one is legal for this port.
- Buffers legal packets in a DEPTH-entry FIFO and presents them to a downstream consumer over a valid/ready stream.
- Keeps saturating receive, drop and error counters and a sticky error flag for the bench and for a status register.

Parameters:
- PORT_ID, 0, index of this egress port (0..3); selects the target bit that must be set.
- PACKET_WIDTH, 16, packet width. Bits [3:0] are the source one-hot, [7:4] the target mask, [PACKET_WIDTH-1:8] the payload.
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- sw_valid  in  1  switch presents a packet this cycle
- sw_data  in  PACKET_WIDTH  packet from the switch
- sw_type  in  2  packet type: 0=UCAST, 1=MCAST, 2=BCAST, 3=reserved
- sw_ready  out  1  advisory space indication, equal to !full
- m_valid  out  1  downstream packet valid
- m_data  out  PACKET_WIDTH  downstream packet
- m_type  out  2  downstream packet type
- m_ready  in  1  downstream accepts the packet
- rx_cnt  out  CNT_W  packets written to the FIFO
- drop_cnt  out  CNT_W  packets rejected because the FIFO was full
- err_cnt  out  CNT_W  packets rejected as illegal
- err_sticky  out  1  set by any illegal packet
- err_clr  in  1  clears err_sticky
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst high at a clk edge): FIFO emptied and pointers zeroed. m_valid=0, m_data=0, m_type=0. All counters 0, err_sticky=0, fifo_count=0, sw_ready=1. Reset takes priority over every other event in that cycle and may arrive mid-transfer; in-flight data is discarded.
- Legality check, combinational on the sw_valid cycle. A packet is illegal if any of the following holds:
  - target bit [4+PORT_ID] is clear (misroute);
  - the source field is not exactly one-hot;
  - UCAST and the target mask is not exactly one-hot;
  - MCAST and the target mask has fewer than 2 bits set;
  - BCAST and the target mask is not 4'b1111;
  - the type is reserved.
- Outcome per sw_valid cycle, mutually exclusive, priority in this order:
  1. Illegal: not written, err_cnt+1, err_sticky set.
  2. FIFO full and no pop in the same cycle: dropped, drop_cnt+1.
  3. Otherwise: written, rx_cnt+1.
- Full is evaluated before this cycle's pop, but a simultaneous pop frees the slot, so the write proceeds. The FIFO never loses an entry.
- Counters saturate at all-ones and do not wrap.
- err_clr and a new error in the same cycle: err_sticky stays 1 (set wins).
- Output stage is a registered head with FSM states EMPTY and HOLD.
  - EMPTY -> HOLD when the FIFO is non-empty. The head loads into m_data/m_type and m_valid=1.
  - In HOLD, m_valid, m_data and m_type are stable until m_ready is seen with m_valid.
  - On handshake, the next entry is loaded in the same cycle if present (HOLD persists, no bubble); otherwise the state returns to EMPTY.
- Latency: a packet written at edge N is on m_valid at edge N+1 when the output stage is empty. Sustained throughput is 1 packet/cycle with m_ready held high.
- fifo_count counts FIFO entries plus the HOLD register, range 0..DEPTH+1.
- Pointers are $clog2(DEPTH) bits and wrap naturally.
- Full is asserted when the FIFO storage holds DEPTH entries; the HOLD register is extra.
- Ordering: packets leave m_data in exact acceptance order.

Test Plan:
- Reset check: drive rst for 10 cycles -> m_valid=0, all counters 0, fifo_count=0, sw_ready=1; the same holds when reset is asserted with 5 packets queued.
- Basic path with PORT_ID=2, m_ready=1: send UCAST 0x5A41 (src=1, tgt=4'b0100) -> m_data=0x5A41 one cycle later, rx_cnt=1, err_cnt=0.
- Misroute and type errors:
  - UCAST tgt=4'b0001 to PORT_ID=2 -> not delivered, err_cnt=1, err_sticky=1.
  - BCAST tgt=4'b0111 -> err_cnt=2.
  - err_clr pulse -> err_sticky=0, err_cnt stays 2.
- Overflow: m_ready=0, send 12 legal packets back-to-back -> 9 accepted (8 FIFO + 1 HOLD), drop_cnt=3, fifo_count=9. Release m_ready -> exactly 9 packets out in order.
- Full with simultaneous pop: FIFO full, pulse m_ready on the same cycle as a new legal packet -> no drop, rx_cnt increments, fifo_count unchanged.
- Saturation: force counter preload or run 65,540 legal packets -> rx_cnt holds 16'hFFFF, no wrap.
